mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter AW, default 16, SHALL set the memory address width.
REQ-003 Parameter DW, default 32, SHALL set the memory data width.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum number of BUSY cycles allowed before abort (>=2).
REQ-005 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port resetN  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 Port req  input  NREQ  SHALL carry the per-requester access request, held high until that requester's done or err.
REQ-008 Port we  input  NREQ  SHALL carry the per-requester write enable (1=write, 0=read).
REQ-009 Port addr  input  NREQ*AW  SHALL carry the packed addresses; requester i occupies bits [i*AW +: AW].
REQ-010 Port wdata  input  NREQ*DW  SHALL carry the packed write data; requester i occupies bits [i*DW +: DW].
REQ-011 Port rdata  output  DW  SHALL carry the shared read-data return.
REQ-012 Port done  output  NREQ  SHALL carry the one-hot completion pulse.
REQ-013 Port err  output  NREQ  SHALL carry the one-hot timeout-abort pulse.
REQ-014 Port mem_req  output  1  SHALL carry the memory request to the MIU.
REQ-015 Port mem_we  output  1  SHALL carry the memory write enable.
REQ-016 Port mem_addr  output  AW  SHALL carry the memory address.
REQ-017 Port mem_write  output  DW  SHALL carry the memory write data.
REQ-018 Port mem_read  input  DW  SHALL carry the memory read data, valid while mem_done=1.
REQ-019 Port mem_done  input  1  SHALL carry the one-cycle memory completion pulse.

Function
REQ-020 The block SHALL implement states IDLE, BUSY and RESP.
REQ-021 In IDLE with any req bit set, the block SHALL grant the first set bit found searching upward from ptr, wrapping modulo NREQ.
REQ-022 On the grant edge, the block SHALL register the granted addr, we and wdata onto mem_addr, mem_we and mem_write, set mem_req=1 and enter BUSY, so that mem_req is high one cycle after req is sampled.
REQ-023 In IDLE with req=0, the block SHALL keep mem_req=0 and hold all other outputs.
REQ-024 In BUSY, mem_req and the mem_* outputs SHALL stay constant, and req/addr/we/wdata changes SHALL be ignored.
REQ-025 mem_done sampled high in BUSY SHALL clear mem_req, latch mem_read into rdata for reads (rdata unchanged for writes) and enter RESP.
REQ-026 In RESP, done[g] SHALL be high for exactly one cycle, ptr SHALL become (g+1) mod NREQ, and the next state SHALL be IDLE.
REQ-027 A 0-based BUSY cycle counter SHALL reach TIMEOUT-1 without mem_done to force abort: mem_req=0, rdata=0, enter RESP, pulse err[g] instead of done[g], advance ptr as in REQ-026.
REQ-028 mem_done and the timeout SHALL coincide when mem_done is sampled on the counter's last cycle; mem_done SHALL then win, giving a normal completion.
REQ-029 mem_done sampled in IDLE or RESP SHALL be ignored.
REQ-030 done and err SHALL never be high simultaneously, and at most one bit of each SHALL be set.
REQ-031 A requester still holding req in the IDLE cycle after RESP SHALL be treated as a new request, with lowest priority under round-robin.
REQ-032 Worst-case grant wait for any requester holding req SHALL be NREQ-1 full transactions.

Reset
REQ-033 resetN=0 SHALL immediately force state=IDLE, ptr=0, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_write=0, rdata=0, done=0 and err=0.
REQ-034 Reset asserted in BUSY SHALL abandon the transaction with no done/err pulse, and a mem_done after reset release SHALL be ignored per REQ-029.
REQ-035 The first grant after reset SHALL use ptr=0.

Verification
REQ-036 Single read: req=4'b0010, addr1=16'h0040, we=0; MIU returns mem_done with mem_read=32'hDEADBEEF after 3 cycles -> mem_req high 1 cycle after req, mem_addr=16'h0040, done=4'b0010 for 1 cycle, rdata=32'hDEADBEEF.
REQ-037 Single write: req=4'b0001, we=1, addr0=16'h0100, wdata0=32'h12345678 -> mem_we=1, mem_write=32'h12345678, done=4'b0001, rdata unchanged.
REQ-038 Round-robin: req=4'b1111 held with each requester dropping after its done -> grant order 0,1,2,3; then re-raise req0 and req2 -> order 0,2.
REQ-039 Timeout: TIMEOUT=8, grant requester 3, never pulse mem_done -> mem_req drops after 8 BUSY cycles, err=4'b1000 for 1 cycle, rdata=0, done stays 0.
REQ-040 Coincidence: TIMEOUT=8, mem_done sampled on the 8th BUSY cycle -> done pulses, err stays 0.
REQ-041 Reset mid-BUSY: resetN low for 2 cycles while BUSY, then a stray mem_done -> all outputs 0 immediately, no done/err, next grant starts at requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a single memory port,
// with a BUSY-cycle timeout that aborts a stalled transaction.
module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_write,
    input  logic [DW-1:0]        mem_read,
    input  logic                 mem_done
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [PW-1:0]     gnt_r, gnt_s;
    logic [PW-1:0]     pick_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [AW-1:0]     mem_addr_r, mem_addr_s;
    logic [DW-1:0]     mem_write_r, mem_write_s;
    logic [DW-1:0]     rdata_r, rdata_s;
    logic [NREQ-1:0]   done_r, done_s;
    logic [NREQ-1:0]   err_r, err_s;
    logic [NREQ-1:0]   gnt_onehot_s;

    // First set request at or above p, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] idx;
        logic [PW-1:0] sel;
        logic          found;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(p) + k) % NREQ);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

    assign pick_s       = rr_pick(req, ptr_r);
    assign gnt_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_r;

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        cnt_s       = cnt_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_write_s = mem_write_r;
        rdata_s     = rdata_r;
        done_s      = {NREQ{1'b0}};
        err_s       = {NREQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    gnt_s       = pick_s;
                    mem_addr_s  = addr[int'(pick_s)*AW +: AW];
                    mem_we_s    = we[pick_s];
                    mem_write_s = wdata[int'(pick_s)*DW +: DW];
                    mem_req_s   = 1'b1;
                    cnt_s       = {CW{1'b0}};
                    state_s     = ST_BUSY;
                end else begin
                    mem_req_s   = 1'b0;
                end
            end
            ST_BUSY: begin
                // mem_done has priority over a timeout landing on the same cycle
                if (mem_done) begin
                    mem_req_s = 1'b0;
                    if (!mem_we_r) begin
                        rdata_s = mem_read;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    done_s  = gnt_onehot_s;
                    state_s = ST_RESP;
                end else if (cnt_r == CW'(TIMEOUT-1)) begin
                    mem_req_s = 1'b0;
                    rdata_s   = {DW{1'b0}};
                    err_s     = gnt_onehot_s;
                    state_s   = ST_RESP;
                end else begin
                    cnt_s     = cnt_r + CW'(1);
                end
            end
            ST_RESP: begin
                if (gnt_r == PW'(NREQ-1)) begin
                    ptr_s = {PW{1'b0}};
                end else begin
                    ptr_s = gnt_r + PW'(1);
                end
                state_s = ST_IDLE;
            end
            default: begin
                mem_req_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {PW{1'b0}};
            gnt_r       <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_write_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
            done_r      <= {NREQ{1'b0}};
            err_r       <= {NREQ{1'b0}};
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_write_r <= mem_write_s;
            rdata_r     <= rdata_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_write = mem_write_r;
    assign rdata     = rdata_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus
// directed scenarios (read, write, reset mid-BUSY, round-robin, timeout, coincidence).
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int TO   = 8;

    logic                clk = 1'b0;
    logic                resetN = 1'b0;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [DW-1:0]       rdata;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic                mem_req;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_write;
    logic [DW-1:0]       mem_read;
    logic                mem_done;

    int checks   = 0;
    int failures = 0;
    int order[$];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetN(resetN), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_first(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: phase 0 = waiting, 1 = memory access open, 2 = reporting.
    int              m_phase, m_owner, m_ptr, m_age, m_pick;
    logic            e_mem_req, e_mem_we;
    logic [AW-1:0]   e_mem_addr;
    logic [DW-1:0]   e_mem_write, e_rdata;
    logic [NREQ-1:0] e_done, e_err;

    assign m_pick = rr_first(req, m_ptr);

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase <= 0; m_owner <= 0; m_ptr <= 0; m_age <= 0;
            e_mem_req <= 1'b0; e_mem_we <= 1'b0; e_mem_addr <= '0;
            e_mem_write <= '0; e_rdata <= '0; e_done <= '0; e_err <= '0;
        end else begin
            e_done <= '0;
            e_err  <= '0;
            if (m_phase == 0) begin
                if (req != '0) begin
                    m_owner     <= m_pick;
                    e_mem_addr  <= addr[m_pick*AW +: AW];
                    e_mem_we    <= we[m_pick];
                    e_mem_write <= wdata[m_pick*DW +: DW];
                    e_mem_req   <= 1'b1;
                    m_age       <= 0;
                    m_phase     <= 1;
                end
            end else if (m_phase == 1) begin
                if (mem_done) begin
                    e_mem_req <= 1'b0;
                    if (!e_mem_we) e_rdata <= mem_read;
                    e_done  <= NREQ'(1) << m_owner;
                    m_phase <= 2;
                end else if (m_age + 1 == TO) begin
                    e_mem_req <= 1'b0;
                    e_rdata   <= '0;
                    e_err     <= NREQ'(1) << m_owner;
                    m_phase   <= 2;
                end else begin
                    m_age <= m_age + 1;
                end
            end else begin
                m_ptr   <= (m_owner + 1) % NREQ;
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        chk("mem_req",   mem_req,   e_mem_req);
        chk("mem_we",    mem_we,    e_mem_we);
        chk("mem_addr",  mem_addr,  e_mem_addr);
        chk("mem_write", mem_write, e_mem_write);
        chk("rdata",     rdata,     e_rdata);
        chk("done",      done,      e_done);
        chk("err",       err,       e_err);
        chk("done_err_excl", done & err, '0);
    end

    task automatic wait_req(output int n);
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mem_req !== 1'b1) chk("grant_wait", mem_req, 1);
    endtask

    task automatic finish_txn(input int extra, input logic [DW-1:0] rd, output int g);
        repeat (extra) @(negedge clk);
        mem_done = 1'b1;
        mem_read = rd;
        @(negedge clk);
        mem_done = 1'b0;
        mem_read = '0;
        g = idx_of(done | err);
        if (g >= 0) req[g] = 1'b0;
    endtask

    task automatic count_busy(output int c);
        c = 0;
        while (mem_req === 1'b1 && c < 40) begin
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, c;
        req = '0; we = '0; mem_done = 1'b0; mem_read = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = 16'h1000 + 16'(i);
            wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        repeat (2) @(negedge clk);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_done", done, 4'b0000);
        chk("reset_rdata", rdata, 32'h0);
        resetN = 1'b1;

        // single read, MIU answers after 3 cycles
        @(negedge clk);
        req = 4'b0010; addr[1*AW +: AW] = 16'h0040;
        wait_req(n);
        chk("t1_latency", n, 1);
        chk("t1_mem_addr", mem_addr, 16'h0040);
        chk("t1_mem_we", mem_we, 1'b0);
        finish_txn(2, 32'hDEADBEEF, g);
        chk("t1_done", done, 4'b0010);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_done_pulse", done, 4'b0000);

        // single write; rdata must keep the previous read value
        req = 4'b0001; we[0] = 1'b1;
        addr[0 +: AW] = 16'h0100; wdata[0 +: DW] = 32'h12345678;
        wait_req(n);
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_write", mem_write, 32'h12345678);
        chk("t2_mem_addr", mem_addr, 16'h0100);
        finish_txn(0, 32'hFFFFFFFF, g);
        chk("t2_done", done, 4'b0001);
        chk("t2_rdata", rdata, 32'hDEADBEEF);
        we[0] = 1'b0;
        @(negedge clk);

        // reset while BUSY, then a stray mem_done
        req = 4'b0100;
        wait_req(n);
        chk("t41_addr", mem_addr, 16'h1002);
        @(negedge clk);
        resetN = 1'b0; req = '0;
        #1;
        chk("t41_mem_req", mem_req, 1'b0);
        chk("t41_mem_addr", mem_addr, 16'h0000);
        chk("t41_rdata", rdata, 32'h0);
        chk("t41_done_err", {done, err}, 8'h00);
        repeat (2) @(negedge clk);
        resetN = 1'b1; mem_done = 1'b1; mem_read = 32'h5555_5555;
        @(negedge clk);
        mem_done = 1'b0; mem_read = '0;
        chk("t41_stray_req", mem_req, 1'b0);
        chk("t41_stray_done", {done, err}, 8'h00);
        @(negedge clk);
        chk("t41_stray_done2", {done, err}, 8'h00);

        // round-robin from ptr=0, then requesters 0 and 2 again
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_req(n);
            finish_txn(1, 32'h0000_0100 + 32'(k), g);
            order.push_back(g);
        end
        req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            wait_req(n);
            finish_txn(1, 32'h0000_0200 + 32'(k), g);
            order.push_back(g);
        end
        chk("rr_len", order.size(), 6);
        if (order.size() == 6) begin
            chk("rr_0", order[0], 0); chk("rr_1", order[1], 1);
            chk("rr_2", order[2], 2); chk("rr_3", order[3], 3);
            chk("rr_4", order[4], 0); chk("rr_5", order[5], 2);
        end
        @(negedge clk);

        // timeout abort on requester 3
        req = 4'b1000;
        wait_req(n);
        count_busy(c);
        chk("t39_busy_cycles", c, 8);
        chk("t39_err", err, 4'b1000);
        chk("t39_done", done, 4'b0000);
        chk("t39_rdata", rdata, 32'h0);
        req = '0;
        @(negedge clk);
        chk("t39_err_pulse", err, 4'b0000);

        // mem_done on the last BUSY cycle wins over the timeout
        req = 4'b1000;
        wait_req(n);
        finish_txn(7, 32'hCAFEF00D, g);
        chk("t40_done", done, 4'b1000);
        chk("t40_err", err, 4'b0000);
        chk("t40_rdata", rdata, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
